// File: rtl/wb_intercon_rr_pkg.sv
// Shared types and helpers for the round-robin Wishbone interconnect.
// Holds FSM encodings, size limits and the counter-width helper.
package wb_intercon_rr_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_SLAVES  = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin arbiter with cycle ownership.
// The owner keeps the bus until it drops cyc; the pointer then moves past it.
module wb_rr_arbiter
  import wb_intercon_rr_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   drop,
  output logic [NUM_MASTERS-1:0] grant
);

  localparam int IW = clog2w(NUM_MASTERS);

  arb_state_t             state;
  arb_state_t             state_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [NUM_MASTERS-1:0] pick;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          ptr_n;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          after;
  logic [IW-1:0]          j;
  logic                   found;

  // first requester at or after the pointer, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = IW'((int'(ptr) + i) % NUM_MASTERS);
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
      end
    end
  end

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant[i]) owner = IW'(i);
  end

  assign after = (int'(owner) == NUM_MASTERS - 1) ? '0 : owner + IW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          state_n = ST_OWNED;
          grant_n = pick;
        end
      end
      ST_OWNED: begin
        if (drop) begin
          state_n = ST_IDLE;
          grant_n = '0;
          ptr_n   = after;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/wb_intercon_rr.sv
// Shared-bus Wishbone interconnect: round-robin arbitration, base/mask
// decode, unmapped-address error responder and bus-timeout watchdog.
module wb_intercon_rr
  import wb_intercon_rr_pkg::*;
#(
  parameter int                         NUM_MASTERS    = 2,
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK     = {NUM_SLAVES{32'hF0000000}},
  parameter int                         TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [NUM_SLAVES-1:0]     s_cyc_o,
  output logic [NUM_SLAVES-1:0]     s_stb_o,
  input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]     s_ack_i,
  input  logic [NUM_SLAVES-1:0]     s_err_i,
  input  logic [NUM_SLAVES-1:0]     s_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int MW = clog2w(NUM_MASTERS);
  localparam int SW = clog2w(NUM_SLAVES);
  localparam int CW = clog2w(TIMEOUT_CYCLES + 1);
  localparam logic          WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CMAX  = '1;

  logic [NUM_MASTERS-1:0] grant;
  logic [MW-1:0]          oidx;
  logic                   ovalid;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   drop;
  logic [NUM_SLAVES-1:0]  sel_oh;
  logic [SW-1:0]          sidx;
  logic                   hit;
  logic                   sack;
  logic                   serr;
  logic                   srty;
  logic                   ue_q;
  logic                   ue_err;
  logic                   stall;
  logic                   wd_fire;
  logic [CW-1:0]          cnt;

  assign drop = ~|(m_cyc_i & grant);

  wb_rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (m_cyc_i),
    .drop (drop),
    .grant(grant)
  );

  always_comb begin
    oidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant[i]) oidx = MW'(i);
  end

  assign ovalid  = |grant;
  assign own_cyc = ovalid & m_cyc_i[oidx];
  assign own_stb = ovalid & m_stb_i[oidx];

  assign s_adr_o = ovalid ? m_adr_i[32*oidx +: 32] : '0;
  assign s_dat_o = ovalid ? m_dat_i[32*oidx +: 32] : '0;
  assign s_sel_o = ovalid ? m_sel_i[4*oidx +: 4] : '0;
  assign s_we_o  = ovalid & m_we_i[oidx];

  // descending scan so the lowest matching index wins
  always_comb begin
    hit    = 1'b0;
    sidx   = '0;
    sel_oh = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (ovalid && ((s_adr_o & SLAVE_MASK[32*i +: 32]) ==
                     (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]))) begin
        hit       = 1'b1;
        sidx      = SW'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign sack    = hit & s_ack_i[sidx];
  assign serr    = hit & s_err_i[sidx];
  assign srty    = hit & s_rty_i[sidx];
  assign m_dat_o = hit ? s_dat_i[32*sidx +: 32] : '0;

  assign ue_err  = ue_q & own_cyc & own_stb & ~hit;
  assign stall   = own_cyc & own_stb & ~(sack | serr | srty | ue_err);
  assign wd_fire = WD_EN & stall & (cnt == LIMIT);

  assign s_cyc_o   = own_cyc ? sel_oh : '0;
  assign s_stb_o   = (own_cyc & own_stb & ~wd_fire) ? sel_oh : '0;
  assign m_ack_o   = sack ? grant : '0;
  assign m_err_o   = (serr | ue_err | wd_fire) ? grant : '0;
  assign m_rty_o   = srty ? grant : '0;
  assign grant_o   = grant;
  assign timeout_o = wd_fire;

  // responder pulse cannot repeat back-to-back; counter saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ue_q <= 1'b0;
      cnt  <= '0;
    end else begin
      ue_q <= own_cyc & own_stb & ~hit & ~ue_q;
      if (!stall || wd_fire)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_intercon_rr.sv
// Bench for wb_intercon_rr: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural bus model.
module tb_wb_intercon_rr;

  localparam int NM    = 2;
  localparam int NS    = 4;
  localparam int TO    = 8;
  localparam int WDMAX = (1 << $clog2(TO + 1)) - 1;
  localparam logic [32*NS-1:0] BASE =
    {32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000};
  localparam logic [32*NS-1:0] MASK = {NS{32'hF000_0000}};

  logic             clk = 1'b0;
  logic             reset;
  logic [32*NM-1:0] m_adr_i;
  logic [32*NM-1:0] m_dat_i;
  logic [4*NM-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [32*NS-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;
  logic [NS-1:0]    s_err_i;
  logic [NS-1:0]    s_rty_i;
  logic [NM-1:0]    grant_o;
  logic             timeout_o;

  always #5 clk = ~clk;

  wb_intercon_rr #(
    .NUM_MASTERS   (NM),
    .NUM_SLAVES    (NS),
    .SLAVE_BASE    (BASE),
    .SLAVE_MASK    (MASK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_we_i   (m_we_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_rty_o  (m_rty_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  int total = 0;
  int bad   = 0;

  // model state: owner index (-1 = none), priority pointer, stall count
  int own = -1;
  int ptr = 0;
  int wd  = 0;
  bit ue  = 1'b0;

  logic [31:0]   e_adr, e_dat, e_mdat;
  logic [3:0]    e_sel;
  logic          e_we, e_to;
  logic [NS-1:0] e_scyc, e_sstb;
  logic [NM-1:0] e_ack, e_err, e_rty, e_grant;
  bit            e_stall, e_fire, e_ue_next;

  int            held[NM];
  logic [NM-1:0] g, prev;
  int            gap, acks;
  logic [NM-1:0] seq[$];
  int            gaps[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32]))
        return i;
    return -1;
  endfunction

  task automatic model_reset();
    own = -1;
    ptr = 0;
    wd  = 0;
    ue  = 1'b0;
  endtask

  task automatic eval();
    int s;
    bit oc, os, sa, se, sr, uo;
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_mdat = '0;
    e_scyc = '0; e_sstb = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_grant = '0;
    oc = 1'b0; os = 1'b0; s = -1;
    if (own >= 0) begin
      oc = m_cyc_i[own];
      os = m_stb_i[own];
      e_adr = m_adr_i[32*own +: 32];
      e_dat = m_dat_i[32*own +: 32];
      e_sel = m_sel_i[4*own +: 4];
      e_we  = m_we_i[own];
      e_grant[own] = 1'b1;
      s = decode(e_adr);
    end
    sa = 1'b0; se = 1'b0; sr = 1'b0;
    if (s >= 0) begin
      sa = s_ack_i[s];
      se = s_err_i[s];
      sr = s_rty_i[s];
      e_mdat = s_dat_i[32*s +: 32];
    end
    uo = ue && oc && os && (s < 0);
    e_stall = oc && os && !(sa || se || sr || uo);
    e_fire  = (TO > 0) && e_stall && (wd == TO - 1);
    if (s >= 0) begin
      e_scyc[s] = oc;
      e_sstb[s] = oc && os && !e_fire;
    end
    if (own >= 0) begin
      e_ack[own] = sa;
      e_err[own] = se || uo || e_fire;
      e_rty[own] = sr;
    end
    e_to = e_fire;
    e_ue_next = oc && os && (s < 0) && !ue;
  endtask

  task automatic advance();
    if (reset) begin
      model_reset();
      return;
    end
    ue = e_ue_next;
    if (!e_stall || e_fire) wd = 0;
    else if (wd < WDMAX) wd++;
    if (own < 0) begin
      for (int k = 0; k < NM; k++) begin
        if (own < 0 && m_cyc_i[(ptr + k) % NM]) own = (ptr + k) % NM;
      end
    end else if (!m_cyc_i[own]) begin
      ptr = (own + 1) % NM;
      own = -1;
    end
  endtask

  task automatic compare();
    chk("grant", grant_o, e_grant);
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", s_dat_o, e_dat);
    chk("s_sel", s_sel_o, e_sel);
    chk("s_we", s_we_o, e_we);
    chk("s_cyc", s_cyc_o, e_scyc);
    chk("s_stb", s_stb_o, e_sstb);
    chk("m_dat", m_dat_o, e_mdat);
    chk("m_ack", m_ack_o, e_ack);
    chk("m_err", m_err_o, e_err);
    chk("m_rty", m_rty_o, e_rty);
    chk("timeout", timeout_o, e_to);
  endtask

  task automatic step();
    @(negedge clk);
    eval();
    compare();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic mset(input int i, input logic c, input logic s,
                      input logic [31:0] a);
    m_cyc_i[i] = c;
    m_stb_i[i] = s;
    m_adr_i[32*i +: 32] = a;
  endtask

  initial begin
    reset   = 1'b1;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0;
    s_dat_i = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004};
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    #2;
    chk("rst_grant", grant_o, 0);
    chk("rst_scyc", s_cyc_o, 0);
    chk("rst_merr", m_err_o, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // round robin with both masters always requesting
    prev = '0; gap = 0;
    for (int i = 0; i < NM; i++) held[i] = 0;
    mset(0, 1'b1, 1'b1, 32'h4000_0000);
    mset(1, 1'b1, 1'b1, 32'h4000_0100);
    for (int c = 0; c < 30; c++) begin
      settle();
      g = grant_o;
      if (g != prev && g != 0) begin
        seq.push_back(g);
        gaps.push_back(gap);
      end
      if (g != prev) gap = 0;
      if (g == 0) gap++;
      prev = g;
      for (int i = 0; i < NM; i++)
        if (g[i] && m_cyc_i[i]) held[i]++;
      step();
      for (int i = 0; i < NM; i++) begin
        if (held[i] == 3) begin
          m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0; held[i] = 0;
        end else begin
          m_cyc_i[i] = 1'b1; m_stb_i[i] = 1'b1;
        end
      end
    end
    chk("rr_count", 32'(seq.size() >= 4), 1);
    if (seq.size() >= 4) begin
      chk("rr_g0", seq[0], 2'b01);
      chk("rr_g1", seq[1], 2'b10);
      chk("rr_g2", seq[2], 2'b01);
      chk("rr_g3", seq[3], 2'b10);
      chk("rr_gap1", gaps[1], 1);
      chk("rr_gap2", gaps[2], 1);
      chk("rr_gap3", gaps[3], 1);
    end
    m_cyc_i = '0; m_stb_i = '0;
    repeat (3) step();

    // single-master read from slave0
    m_sel_i = 8'hFF;
    mset(0, 1'b1, 1'b1, 32'h4000_0010);
    s_dat_i[31:0] = 32'hDEAD_BEEF;
    step();
    settle();
    chk("rd_grant", grant_o, 2'b01);
    chk("rd_scyc", s_cyc_o, 4'b0001);
    step();
    s_ack_i = 4'b0001;
    settle();
    chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("rd_ack", m_ack_o, 2'b01);
    step();
    s_ack_i = '0;
    mset(0, 1'b0, 1'b0, 32'h0);
    repeat (2) step();

    // locked burst: master1 waits while master0 holds cyc
    mset(0, 1'b1, 1'b1, 32'h4000_0020);
    step();
    mset(1, 1'b1, 1'b1, 32'h5000_0000);
    acks = 0;
    for (int c = 1; c <= 9; c++) begin
      s_ack_i[0] = (c % 2 == 0) && (c <= 8);
      if (c == 9) mset(0, 1'b0, 1'b0, 32'h4000_0020);
      settle();
      chk("burst_grant", grant_o, 2'b01);
      if (m_ack_o[0]) acks++;
      step();
    end
    s_ack_i = '0;
    chk("burst_beats", acks, 4);
    settle();
    chk("burst_idle", grant_o, 0);
    step();
    settle();
    chk("burst_m1", grant_o, 2'b10);
    step();
    mset(1, 1'b0, 1'b0, 32'h0);
    repeat (2) step();

    // unmapped address
    mset(1, 1'b1, 1'b1, 32'h9000_0000);
    step();
    settle();
    chk("ue_grant", grant_o, 2'b10);
    chk("ue_scyc", s_cyc_o, 0);
    chk("ue_err1", m_err_o, 0);
    step();
    settle();
    chk("ue_err2", m_err_o, 2'b10);
    step();
    settle();
    chk("ue_err3", m_err_o, 0);
    step();
    mset(1, 1'b0, 1'b0, 32'h0);
    repeat (2) step();

    // watchdog fires on the 8th stalled cycle, then ack wins a tie
    for (int run = 0; run < 2; run++) begin
      mset(0, 1'b1, 1'b1, 32'h6000_0040);
      step();
      for (int k = 1; k <= 8; k++) begin
        if (run == 1 && k == 8) s_ack_i[2] = 1'b1;
        settle();
        if (k < 8) begin
          chk("to_quiet", timeout_o, 0);
        end else if (run == 0) begin
          chk("to_fire", timeout_o, 1);
          chk("to_err", m_err_o, 2'b01);
          chk("to_stb", s_stb_o[2], 0);
        end else begin
          chk("to_ack", m_ack_o, 2'b01);
          chk("to_noerr", m_err_o, 0);
          chk("to_nofire", timeout_o, 0);
        end
        step();
      end
      s_ack_i = '0;
      mset(0, 1'b0, 1'b0, 32'h0);
      repeat (2) step();
    end

    // async reset mid-wait on slave1
    mset(1, 1'b1, 1'b1, 32'h5000_0008);
    repeat (3) step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_grant", grant_o, 0);
    chk("ar_scyc", s_cyc_o, 0);
    chk("ar_sstb", s_stb_o, 0);
    chk("ar_sadr", s_adr_o, 0);
    chk("ar_mdat", m_dat_o, 0);
    chk("ar_merr", m_err_o, 0);
    step();
    reset = 1'b0;
    mset(0, 1'b1, 1'b1, 32'h4000_0000);
    step();
    settle();
    chk("ar_ptr", grant_o, 2'b01);
    step();
    m_cyc_i = '0; m_stb_i = '0;
    repeat (3) step();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (reset) model_reset();
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 7) == 0) m_cyc_i[i] = ~m_cyc_i[i];
        m_stb_i[i] = m_cyc_i[i] & ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0)
          m_adr_i[32*i +: 32] = {4'($urandom_range(4, 9)), 28'($urandom())};
        m_dat_i[32*i +: 32] = $urandom();
        m_sel_i[4*i +: 4] = 4'($urandom());
        m_we_i[i] = 1'($urandom());
      end
      for (int j = 0; j < NS; j++) begin
        s_dat_i[32*j +: 32] = $urandom();
        s_ack_i[j] = ($urandom_range(0, (j == 3) ? 15 : 3) == 0);
        s_err_i[j] = ($urandom_range(0, 11) == 0);
        s_rty_i[j] = ($urandom_range(0, 11) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
